icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Miss-service engine directly downstream of the L1 instruction cache.
- Accepts the cache's registered read request and fetches either:
  - a full 32-byte line as eight 32-bit beats from the memory word bus, assembled into a 256-bit line, or
  - for MMIO addresses, a single uncached word.
- Returns the result with a one-cycle done pulse. Owns the cache-facing request/done handshake and the memory-side request/acknowledge handshake.

Parameters:
- LINE_WORDS, 8, words per cache line; fixed, the line is 256 bits.
- BEAT_ADDR_STEP, 4, byte increment between beats.

Ports:
- sys_clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- l1_mmu_req_read  in  1  registered read request from the I-cache.
- l1_mmu_req_addr  in  32  request byte address; bits [4:0] ignored for cached fills.
- mmu_l1_done  out  1  one-cycle pulse: fill/read complete, data valid.
- mmu_l1_read_data  out  256  assembled line; for MMIO, the word in [31:0] and zeros above.
- mem_req  out  1  memory beat request; held until acknowledged.
- mem_addr  out  32  word-aligned beat address; stable while mem_req is high.
- mem_ack  in  1  beat accepted, mem_rdata valid this cycle; may assert in the same cycle mem_req rises.
- mem_rdata  in  32  beat read data.

Behaviour:
- Reset (synchronous, sys_clk edge with rst=1):
  - state=IDLE, beat counter=0.
  - mem_req=0, mem_addr=0, mmu_l1_done=0, mmu_l1_read_data=0.
  - Reset asserted mid-burst abandons the burst: mem_req low after that edge, no done pulse.
- States: IDLE, FETCH, DONE, RELEASE.
- IDLE:
  - When l1_mmu_req_read=1, capture the address and the MMIO flag (from mmio_addr).
  - Base address: cached = addr & ~32'h1F, beats=8; MMIO = addr & ~32'h3, beats=1.
  - Clear the data register. Go to FETCH with mem_req=1 and mem_addr=base.
- FETCH:
  - On each cycle with mem_req & mem_ack: write mem_rdata into word slot k = beat counter (bits [32k+31:32k]), increment the counter, and add 4 to mem_addr.
  - On the acknowledge of the final beat: drop mem_req and go to DONE.
  - Without mem_ack, hold mem_req, mem_addr and the counter unchanged. There is no timeout.
- DONE: mmu_l1_done=1 for exactly one cycle. mmu_l1_read_data is stable; go to RELEASE.
- RELEASE:
  - One cooldown cycle; the request input is ignored.
  - This absorbs the registered request that is still high in the cycle after done. Then go to IDLE.
- mmu_l1_read_data holds its value from DONE until the next capture in IDLE.
- Latency with zero-wait memory (request sampled at edge 0):
  - Beats ack at cycles 1..8; done high in cycle 9; IDLE again at cycle 11.
  - MMIO: done in cycle 2.
- Request deasserted mid-FETCH: ignored. The burst completes and done still pulses (the cache discards it).
- Address wrap: mem_addr increments stay within the 32-byte-aligned line; no carry beyond bit 4 is possible for cached fills.
- Back-to-back misses: a request high in the cycle after RELEASE starts a new fill normally.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, DONE, RELEASE), LINE_WORDS=8, LINE_BYTES=32, line-offset mask 32'h1F, word mask 32'h3.
- Instantiate the existing mmio_addr decoder (addr → is_mmio) on l1_mmu_req_addr.
- No new sub-module; counter, address and line register are inline.

Test Plan:
- Cached fill, zero-wait memory, addr 0x0000_1234:
  - mem_addr goes 0x1220, 0x1224 … 0x123C; memory returns 0xA0..0xA7.
  - Done in cycle 9 with data[31:0]=0xA0 and data[255:224]=0xA7.
- Wait states: mem_ack held low for 3 cycles on beat 2 → mem_req and mem_addr=0x1228 held; done delayed by exactly 3 cycles.
- MMIO read at 0xFFFF_FC04 returning 0xDEAD_BEEF → a single beat at 0xFFFF_FC04; data[31:0]=0xDEADBEEF, upper 224 bits zero; done in cycle 2.
- Request held high continuously across two misses (0x100, then 0x2000) → RELEASE ignores the stale cycle, then the second fill starts; two separate done pulses.
- rst=1 during beat 5 → mem_req=0, data=0, state IDLE next cycle; no done pulse; a subsequent request fills correctly.
- Request dropped after beat 3 → remaining beats still fetched and a done pulse is issued.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
//   Shared definitions for the I-cache refill engine: FSM state encoding,
//   line geometry and the address masks used to form beat base addresses.
// -----------------------------------------------------------------------------
package icache_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } refill_state_e;

    localparam int          LINE_WORDS       = 8;
    localparam int          LINE_BYTES       = 32;
    localparam int          BEAT_ADDR_STEP   = 4;
    localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_001F;
    localparam logic [31:0] WORD_MASK        = 32'h0000_0003;

    // Base address of the first beat: line-aligned for cached fills,
    // word-aligned for a single uncached MMIO word.
    function automatic logic [31:0] beat_base(input logic [31:0] addr,
                                              input logic        is_mmio);
        beat_base = is_mmio ? (addr & ~WORD_MASK) : (addr & ~LINE_OFFSET_MASK);
    endfunction

endpackage

// File: rtl/mmio_addr.sv
// -----------------------------------------------------------------------------
// mmio_addr
//   Address-space decoder: flags addresses that fall in the uncached MMIO
//   window (everything at or above MMIO_BASE).
//   Ports:
//     addr    in  32  byte address to classify
//     is_mmio out  1  high when addr is in the MMIO window
// -----------------------------------------------------------------------------
module mmio_addr #(
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic [31:0] addr,
    output logic        is_mmio
);

    assign is_mmio = (addr >= MMIO_BASE);

endmodule

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
//   Miss-service engine for the L1 instruction cache. On a read request it
//   fetches a full 32-byte line as eight 32-bit beats (or a single word for
//   MMIO addresses) over a req/ack memory word bus, assembles the line and
//   signals completion with a one-cycle done pulse.
//   Ports:
//     sys_clk          in   1   system clock, all state on posedge
//     rst              in   1   synchronous active-high reset
//     l1_mmu_req_read  in   1   registered read request from the I-cache
//     l1_mmu_req_addr  in   32  request byte address
//     mmu_l1_done      out  1   one-cycle completion pulse
//     mmu_l1_read_data out  256 assembled line (MMIO word in [31:0])
//     mem_req          out  1   beat request, held until acknowledged
//     mem_addr         out  32  word-aligned beat address
//     mem_ack          in   1   beat accepted, mem_rdata valid this cycle
//     mem_rdata        in   32  beat read data
// -----------------------------------------------------------------------------
module icache_refill #(
    parameter int LINE_WORDS     = 8,
    parameter int BEAT_ADDR_STEP = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     l1_mmu_req_read,
    input  logic [31:0]              l1_mmu_req_addr,
    output logic                     mmu_l1_done,
    output logic [LINE_WORDS*32-1:0] mmu_l1_read_data,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata
);

    import icache_refill_pkg::*;

    localparam int CNT_W = $clog2(LINE_WORDS);

    refill_state_e    state_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic [CNT_W-1:0] last_beat_reg;
    logic             mem_req_reg;
    logic [31:0]      mem_addr_reg;
    logic             done_reg;
    logic [31:0]      line_reg [LINE_WORDS];

    logic             is_mmio;
    logic             capture;
    logic             beat_fire;

    mmio_addr u_mmio_addr (
        .addr    (l1_mmu_req_addr),
        .is_mmio (is_mmio)
    );

    // A new miss is accepted only from IDLE; RELEASE deliberately ignores the
    // request so the cache's still-high registered request is not re-taken.
    assign capture   = (state_reg == ST_IDLE) && l1_mmu_req_read;
    assign beat_fire = (state_reg == ST_FETCH) && mem_req_reg && mem_ack;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            beat_cnt_reg  <= '0;
            last_beat_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (capture) begin
                        mem_addr_reg  <= beat_base(l1_mmu_req_addr, is_mmio);
                        last_beat_reg <= is_mmio ? '0 : CNT_W'(LINE_WORDS - 1);
                        beat_cnt_reg  <= '0;
                        mem_req_reg   <= 1'b1;
                        state_reg     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Without an ack everything holds: no timeout by design.
                    if (beat_fire) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        mem_addr_reg <= mem_addr_reg + 32'(BEAT_ADDR_STEP);
                        if (beat_cnt_reg == last_beat_reg) begin
                            mem_req_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            state_reg   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Line register: one 32-bit slot per beat. Cleared on capture so MMIO
    // reads return zeros above the word; otherwise holds until next capture.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
            always_ff @(posedge sys_clk) begin
                if (rst || capture) begin
                    line_reg[gi] <= '0;
                end else if (beat_fire && (beat_cnt_reg == CNT_W'(gi))) begin
                    line_reg[gi] <= mem_rdata;
                end
            end
            assign mmu_l1_read_data[32*gi +: 32] = line_reg[gi];
        end
    endgenerate

    assign mmu_l1_done = done_reg;
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;

endmodule

// File: tb/tb_icache_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_refill
//   Directed bench for icache_refill. A cycle-stepped memory responder answers
//   beats with data derived from the beat address; each scenario task checks
//   latency, address sequence and assembled data against hand-derived values.
// -----------------------------------------------------------------------------
module tb_icache_refill;

    logic         sys_clk;
    logic         rst;
    logic         l1_mmu_req_read;
    logic [31:0]  l1_mmu_req_addr;
    logic         mmu_l1_done;
    logic [255:0] mmu_l1_read_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    int errors = 0;
    int checks = 0;

    // Memory responder state
    logic [31:0]  resp_base   = 32'h0;
    logic         mmio_mode   = 1'b0;
    logic [31:0]  stall_addr  = 32'h0;
    int           stall_left  = 0;
    int           stalled_cycles = 0;
    logic [31:0]  acked [$];

    icache_refill dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .l1_mmu_req_read  (l1_mmu_req_read),
        .l1_mmu_req_addr  (l1_mmu_req_addr),
        .mmu_l1_done      (mmu_l1_done),
        .mmu_l1_read_data (mmu_l1_read_data),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Answer the beat currently presented (outputs are stable after the edge).
    task automatic drive_mem();
        if (mem_req === 1'b1) begin
            if (stall_left > 0 && mem_addr == stall_addr) begin
                mem_ack = 1'b0;
                stall_left--;
                stalled_cycles++;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = mmio_mode ? 32'hDEAD_BEEF : resp_base + 32'(mem_addr[4:2]);
                acked.push_back(mem_addr);
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        drive_mem();
    endtask

    task automatic settle(input int k);
        l1_mmu_req_read = 1'b0;
        repeat (k) step();
    endtask

    // Steps until a done pulse; n counts edges including the capturing one,
    // n = -1 if no done within the budget.
    task automatic wait_done(input int drop_after, output int n, output logic [255:0] d);
        bit found;
        found = 0;
        n = 0;
        d = '0;
        while (!found && n < 60) begin
            step();
            n++;
            if (drop_after != 0 && n == drop_after) l1_mmu_req_read = 1'b0;
            if (mmu_l1_done === 1'b1) begin
                found = 1;
                d = mmu_l1_read_data;
            end
        end
        if (!found) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++;
        if (mmu_l1_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", mmu_l1_done); end
        checks++;
        if (mmu_l1_read_data !== 256'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mmu_l1_read_data); end
        rst = 1'b0;
        step();
        $display("reset: done");
    endtask

    task automatic test_cached_fill();
        int n;
        logic [255:0] d;
        logic [255:0] exp;
        for (int i = 0; i < 8; i++) exp[32*i +: 32] = 32'hA0 + 32'(i);
        resp_base = 32'hA0;
        acked.delete();
        l1_mmu_req_addr = 32'h0000_1234;
        l1_mmu_req_read = 1'b1;
        wait_done(1, n, d);
        checks++;
        if (n != 9) begin errors++; $display("FAIL fill_latency: got %0d want 9", n); end
        checks++;
        if (d[31:0] !== 32'hA0) begin errors++; $display("FAIL fill_word0: got %h want a0", d[31:0]); end
        checks++;
        if (d[255:224] !== 32'hA7) begin errors++; $display("FAIL fill_word7: got %h want a7", d[255:224]); end
        checks++;
        if (d !== exp) begin errors++; $display("FAIL fill_line: got %h want %h", d, exp); end
        checks++;
        if (acked.size() != 8) begin errors++; $display("FAIL fill_beats: got %0d want 8", acked.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acked[i] !== 32'h1220 + 32'(4*i)) begin
                    errors++;
                    $display("FAIL fill_addr%0d: got %h want %h", i, acked[i], 32'h1220 + 32'(4*i));
                end
            end
        end
        step();
        checks++;
        if (mmu_l1_done !== 1'b0) begin errors++; $display("FAIL fill_done_width: got %b want 0", mmu_l1_done); end
        checks++;
        if (mmu_l1_read_data !== exp) begin errors++; $display("FAIL fill_data_hold: got %h want %h", mmu_l1_read_data, exp); end
        settle(3);
        $display("cached_fill: latency=%0d word0=%h word7=%h", n, d[31:0], d[255:224]);
    endtask

    task automatic test_wait_states();
        int n;
        logic [255:0] d;
        resp_base = 32'hA0;
        acked.delete();
        stall_addr = 32'h1228;
        stall_left = 3;
        stalled_cycles = 0;
        l1_mmu_req_addr = 32'h0000_1234;
        l1_mmu_req_read = 1'b1;
        wait_done(1, n, d);
        checks++;
        if (n != 12) begin errors++; $display("FAIL wait_latency: got %0d want 12", n); end
        checks++;
        if (stalled_cycles != 3) begin errors++; $display("FAIL wait_held: got %0d held cycles at 1228 want 3", stalled_cycles); end
        checks++;
        if (acked.size() != 8 || acked[2] !== 32'h1228) begin
            errors++; $display("FAIL wait_beats: got %0d beats want 8 with beat2=1228", acked.size());
        end
        checks++;
        if (d[95:64] !== 32'hA2) begin errors++; $display("FAIL wait_word2: got %h want a2", d[95:64]); end
        stall_left = 0;
        settle(3);
        $display("wait_states: latency=%0d stalled=%0d", n, stalled_cycles);
    endtask

    task automatic test_mmio();
        int n;
        logic [255:0] d;
        mmio_mode = 1'b1;
        acked.delete();
        l1_mmu_req_addr = 32'hFFFF_FC04;
        l1_mmu_req_read = 1'b1;
        wait_done(1, n, d);
        checks++;
        if (n != 2) begin errors++; $display("FAIL mmio_latency: got %0d want 2", n); end
        checks++;
        if (d !== {224'h0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL mmio_data: got %h want deadbeef zero-extended", d); end
        checks++;
        if (acked.size() != 1 || acked[0] !== 32'hFFFF_FC04) begin
            errors++; $display("FAIL mmio_beat: got %0d beats want 1 at fffffc04", acked.size());
        end
        mmio_mode = 1'b0;
        settle(3);
        $display("mmio: latency=%0d data=%h", n, d[31:0]);
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        logic [255:0] d1;
        logic [255:0] d2;
        resp_base = 32'h10;
        acked.delete();
        l1_mmu_req_addr = 32'h0000_0100;
        l1_mmu_req_read = 1'b1;
        wait_done(0, n1, d1);
        l1_mmu_req_addr = 32'h0000_2000;
        wait_done(0, n2, d2);
        l1_mmu_req_read = 1'b0;
        checks++;
        if (n1 != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d want 9", n1); end
        checks++;
        if (n2 != 11) begin errors++; $display("FAIL b2b_second_gap: got %0d want 11", n2); end
        checks++;
        if (acked.size() != 16 || acked[8] !== 32'h2000 || acked[0] !== 32'h100) begin
            errors++; $display("FAIL b2b_beats: got %0d beats want 16 starting 100 then 2000", acked.size());
        end
        checks++;
        if (d2[255:224] !== 32'h17) begin errors++; $display("FAIL b2b_second_word7: got %h want 17", d2[255:224]); end
        settle(3);
        $display("back_to_back: first=%0d second=%0d", n1, n2);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int pulses;
        logic [255:0] d;
        resp_base = 32'h40;
        l1_mmu_req_addr = 32'h0000_4000;
        l1_mmu_req_read = 1'b1;
        step();
        l1_mmu_req_read = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
        checks++;
        if (mmu_l1_read_data !== 256'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", mmu_l1_read_data); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mmu_l1_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", pulses); end
        resp_base = 32'h50;
        l1_mmu_req_read = 1'b1;
        wait_done(1, n, d);
        checks++;
        if (n != 9 || d[159:128] !== 32'h54) begin
            errors++; $display("FAIL rstmid_refill: got latency %0d word4 %h want 9 and 54", n, d[159:128]);
        end
        settle(3);
        $display("reset_mid_burst: pulses=%0d refill_latency=%0d", pulses, n);
    endtask

    task automatic test_req_drop();
        int n;
        logic [255:0] d;
        resp_base = 32'hC0;
        acked.delete();
        l1_mmu_req_addr = 32'h0000_0300;
        l1_mmu_req_read = 1'b1;
        wait_done(4, n, d);
        checks++;
        if (n != 9) begin errors++; $display("FAIL drop_latency: got %0d want 9", n); end
        checks++;
        if (d[255:224] !== 32'hC7 || acked.size() != 8) begin
            errors++; $display("FAIL drop_complete: got word7 %h beats %0d want c7 and 8", d[255:224], acked.size());
        end
        settle(3);
        $display("req_drop: latency=%0d word7=%h", n, d[255:224]);
    endtask

    initial begin
        rst = 1'b1;
        l1_mmu_req_read = 1'b0;
        l1_mmu_req_addr = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_cached_fill();
        test_wait_states();
        test_mmio();
        test_back_to_back();
        test_reset_mid_burst();
        test_req_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
